// File: rtl/ctrl_pipe_mc.sv
// E/M/W control pipeline carrying a W-bit control bundle plus valid bit.
// Long-latency ops are held in E for DIVLAT cycles while F/D is stalled and M is fed bubbles.
module ctrl_pipe_mc #(
  parameter int W      = 16,
  parameter int DIVLAT = 32,
  parameter int CW     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] ctrlD,
  input  logic         validD,
  input  logic         longopD,
  input  logic         flushE,
  output logic [W-1:0] ctrlE,
  output logic         validE,
  output logic         longopE,
  output logic [W-1:0] ctrlM,
  output logic         validM,
  output logic [W-1:0] ctrlW,
  output logic         validW,
  output logic         stall_up,
  output logic         md_start,
  output logic         md_done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic          LONG_EN  = 1'(DIVLAT > 1);
  localparam logic [CW-1:0] CNT_INIT = (DIVLAT > 1) ? CW'(DIVLAT - 2) : '0;

  state_t        state_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0] ctrl_e_q, ctrl_e_d;
  logic         valid_e_q, valid_e_d;
  logic         long_e_q, long_e_d;
  logic [W-1:0] ctrl_m_q, ctrl_m_d;
  logic         valid_m_q, valid_m_d;
  logic [W-1:0] ctrl_w_q;
  logic         valid_w_q;

  logic long_live;
  logic done_c;

  // A live long op in E that is not being flushed; all gated off while in reset.
  always_comb begin
    long_live = ~rst & valid_e_q & long_e_q & ~flushE & LONG_EN;
    done_c    = ~rst & (state_q == BUSY) & (cnt_q == '0) & ~flushE;
  end

  assign md_start = long_live & (state_q == IDLE);
  assign md_done  = done_c;
  assign stall_up = long_live & ~done_c;

  // Next-state of E and M: flush beats stall in E, stall bubbles M.
  always_comb begin
    if (flushE) begin
      ctrl_e_d  = '0;
      valid_e_d = 1'b0;
      long_e_d  = 1'b0;
    end else if (stall_up) begin
      ctrl_e_d  = ctrl_e_q;
      valid_e_d = valid_e_q;
      long_e_d  = long_e_q;
    end else begin
      ctrl_e_d  = ctrlD;
      valid_e_d = validD;
      long_e_d  = longopD;
    end
    if (stall_up) begin
      ctrl_m_d  = '0;
      valid_m_d = 1'b0;
    end else begin
      ctrl_m_d  = ctrl_e_q;
      valid_m_d = valid_e_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e_q  <= '0;
      valid_e_q <= 1'b0;
      long_e_q  <= 1'b0;
      ctrl_m_q  <= '0;
      valid_m_q <= 1'b0;
      ctrl_w_q  <= '0;
      valid_w_q <= 1'b0;
    end else begin
      ctrl_e_q  <= ctrl_e_d;
      valid_e_q <= valid_e_d;
      long_e_q  <= long_e_d;
      ctrl_m_q  <= ctrl_m_d;
      valid_m_q <= valid_m_d;
      ctrl_w_q  <= ctrl_m_q;
      valid_w_q <= valid_m_q;
    end
  end

  // Long-op FSM; cnt counts the remaining hold cycles after the first one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (flushE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
          end else begin
            state_q <= IDLE;
            cnt_q   <= cnt_q;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            state_q <= BUSY;
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ctrlE   = ctrl_e_q;
  assign validE  = valid_e_q;
  assign longopE = long_e_q;
  assign ctrlM   = ctrl_m_q;
  assign validM  = valid_m_q;
  assign ctrlW   = ctrl_w_q;
  assign validW  = valid_w_q;

endmodule

// File: doc/ctrl_pipe_mc.md
Name: ctrl_pipe_mc

Overview:
- Parametrised successor to the fixed-width decode-to-writeback control pipeline.
- Carries a generic W-bit control bundle plus a valid bit through stages E, M and W.
- Adds multi-cycle execute support: a long-latency op (div/mul) is held in E for DIVLAT cycles. During the hold the block back-pressures F/D and injects bubbles into M.
- Sits between maindec/aludec (D stage) and the datapath E/M/W control inputs; the hazard unit drives flushE.

Parameters:
- W, 16, width of the control bundle (memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol, hilo flags, ...).
- DIVLAT, 32, total cycles a long op occupies E; legal range 1..256.
- CW, 8, width of the internal down-counter; must satisfy 2^CW >= DIVLAT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ctrlD  in  W  decoded control bundle for the instruction in D.
- validD  in  1  D holds a real instruction.
- longopD  in  1  instruction in D is a multi-cycle op.
- flushE  in  1  kill the instruction in E (branch/hazard flush).
- ctrlE  out  W  E-stage control bundle.
- validE  out  1  E-stage valid.
- longopE  out  1  E-stage long-op flag.
- ctrlM  out  W  M-stage control bundle.
- validM  out  1  M-stage valid.
- ctrlW  out  W  W-stage control bundle.
- validW  out  1  W-stage valid.
- stall_up  out  1  combinational; freeze PC, F/D and D inputs this cycle.
- md_start  out  1  one-cycle pulse; long op begins in E.
- md_done  out  1  one-cycle pulse; last E cycle of the long op.

Behaviour:
- All registers update on the rising edge of clk only.
- Reset (rst=1 at an edge):
  - ctrlE/M/W = 0; validE/M/W = 0; longopE = 0.
  - state = IDLE; cnt = 0.
  - Combinational outputs evaluate to 0 during reset.
- Bubble definition: ctrl = 0, valid = 0, longop = 0.

FSM states: IDLE, BUSY.
- md_start = (state==IDLE) & validE & longopE & ~flushE & (DIVLAT>1).
- md_done = (state==BUSY) & (cnt==0) & ~flushE.
- stall_up = validE & longopE & ~flushE & (DIVLAT>1) & ~md_done.
- IDLE -> BUSY when md_start; cnt <= DIVLAT-2.
- BUSY, cnt != 0, no flush: cnt <= cnt-1; stay BUSY.
- BUSY, cnt == 0: -> IDLE.
- Any state, flushE=1: -> IDLE, cnt <= 0.

Stage updates, in priority order:
- E register:
  - flushE=1: load bubble.
  - else stall_up=1: hold.
  - else: load {ctrlD, validD, longopD}.
- M register:
  - stall_up=1: load bubble.
  - else: load E.
- W register: always loads M.

Timing and boundary conditions:
- Latency: a normal op enters E, M and W on consecutive edges (1 cycle/stage).
- A long op occupies E for exactly DIVLAT cycles:
  - stall_up is high for DIVLAT-1 cycles.
  - M receives DIVLAT-1 bubbles, then the long op.
- DIVLAT=1: no stall, no md_start/md_done pulses; behaves as a plain 3-stage pipe.
- Back-to-back long ops: the second enters E on the edge after md_done. It sees IDLE and starts a fresh count with no idle gap.
- Flush during BUSY: E becomes a bubble, the FSM returns to IDLE, and stall_up drops in the same cycle. No md_done is issued for the killed op.
- Flush and md_done in the same cycle: flush wins (md_done=0, E bubbled).
- Non-valid entry in E with longopE=1: ignored (no stall).
- Reset mid-BUSY: the next cycle is IDLE with all stages bubbled.
- Counter never wraps: cnt is only decremented when nonzero.

Test Plan (W=16, DIVLAT=4):
- Reset: hold rst 2 cycles with ctrlD=16'hFFFF, validD=1 -> all ctrl/valid outputs 0, stall_up=0; first edge after release ctrlE=16'hFFFF, validE=1.
- Normal stream: feed 16'h0001, 16'h0002, 16'h0003 on consecutive cycles with longopD=0 -> each value appears at ctrlE, ctrlM, ctrlW one cycle apart; stall_up never high.
- Long op: feed 16'h00A5 with longopD=1, then 16'h0011 -> ctrlE=16'h00A5 for 4 cycles; stall_up high 3 cycles; md_start in cycle 1, md_done in cycle 4; ctrlM is a bubble for 3 cycles then 16'h00A5; 16'h0011 enters E in cycle 5.
- Back-to-back long ops 16'h00B1, 16'h00B2 -> 8 total E cycles; md_start pulses in cycles 1 and 5; md_done in cycles 4 and 8.
- Flush mid-op: long op 16'h00C3, assert flushE in its 2nd E cycle -> validE=0 next cycle, stall_up=0 in the flush cycle, no md_done, state IDLE.
- DIVLAT=1 build: long op 16'h00D4 -> passes E in 1 cycle; stall_up, md_start, md_done all stay 0.
